dma_bus_arbiter: RTL and testbench
==================================

# dma_bus_arbiter

Parametrised N-channel arbiter that grants ownership of the shared SDRAM/DMA bus to one requesting channel at a time. It generalises the fixed two-entry DMA ID set (USB, SD) to any channel count. It supports runtime-selectable round-robin or fixed-priority arbitration, per-channel enable masking, and an optional burst quota that forces release when other channels are waiting. It sits between the DMA channel engines and the memory bus master, and drives the bus-owner ID used for routing.

## Interface
Parameters:
- NUM_CH, default 2 (`__ID_DMA_END`): number of requesting channels, legal range 1..16.
- ID_W, default `$clog2(NUM_CH)` (minimum 1): width of the owner ID.
- MAX_BEATS, default 0: burst quota in accepted bus beats; 0 means unlimited.

Ports:
- clk  in  1  system clock (`CLOCK_FREQUENCY`).
- reset_n  in  1  reset; asynchronous assert, active-low.
- mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled only at arbitration.
- ch_enable  in  NUM_CH  per-channel enable mask; a disabled channel is never granted.
- req  in  NUM_CH  level request, held high for the whole transaction.
- bus_ack  in  1  the bus accepted one beat from the current owner.
- grant  out  NUM_CH  one-hot grant, registered.
- grant_valid  out  1  OR of grant.
- grant_id  out  ID_W  binary index of the owner; 0 when not valid.
- busy  out  1  high in states GRANT and RELEASE.

## Operation
- Eligible set: `req & ch_enable`.
- State machine has three states: IDLE, GRANT, RELEASE.
- IDLE:
  - If the eligible set is non-empty, pick a winner combinationally.
  - Register grant, grant_id, and owner; clear beat_cnt; go to GRANT.
  - Otherwise stay in IDLE.
- Winner selection:
  - mode = 1: lowest eligible index.
  - mode = 0: first eligible index at or after rr_ptr, wrapping modulo NUM_CH.
- GRANT:
  - Each bus_ack increments beat_cnt (saturating at MAX_BEATS).
  - Go to RELEASE if `req[owner] == 0`.
  - Go to RELEASE if `ch_enable[owner] == 0`.
  - Go to RELEASE if MAX_BEATS != 0, `bus_ack == 1`, `beat_cnt == MAX_BEATS-1`, and any other channel is eligible in the same cycle.
  - If the quota is reached with no other eligible channel: keep the grant, reset beat_cnt to 0, and continue.
- RELEASE:
  - grant is cleared on entry (registered, so it is low during the RELEASE cycle).
  - rr_ptr <= (owner + 1) mod NUM_CH.
  - Go to IDLE unconditionally.
- rr_ptr updates only in RELEASE. Fixed-priority mode still updates it, so switching mode mid-run is well defined.
- Simultaneous events: release conditions are ORed, with no priority among them. A bus_ack in the same cycle as req dropping is still counted but has no further effect.
- bus_ack while not in GRANT is ignored.
- Width rules: beat_cnt width is `$clog2(MAX_BEATS+1)` (1 bit when MAX_BEATS = 0, unused). rr_ptr and owner are ID_W bits. Wrap-around uses compare-to-(NUM_CH-1), not power-of-two masking.
- Reset (asynchronous, mid-operation included): state = IDLE, grant = 0, grant_valid = 0, grant_id = 0, busy = 0, rr_ptr = 0, beat_cnt = 0, owner = 0.

## Timing
- Grant latency: req rises while in IDLE at edge N, so grant is high after edge N+1 (1 cycle).
- Release to next grant: release condition at edge N, grant low from N+1, state IDLE at N+2, new grant from N+3. This gives a minimum 2-cycle dead gap between owners.
- The owner may drive the bus on any cycle where grant is high. The owner must not assume a beat is accepted without bus_ack.
- Forced quota release: grant drops the cycle after the MAX_BEATS-th bus_ack. The channel keeps req high and is re-arbitrated fairly.
- No combinational path from req, ch_enable, or bus_ack to any output.

## Structure
- Shared package sc64 gains:
  - `typedef enum bit {ARB_ROUND_ROBIN, ARB_FIXED_PRIO} e_arb_mode;`
  - `parameter int DMA_MAX_BEATS` (system default 256).
- NUM_CH is instantiated as `__ID_DMA_END`, and grant_id is cast to `e_dma_id` at the instantiation site.
- One combinational sub-module, `arb_rr_pick`. Inputs: eligible mask, rr_ptr, mode. Outputs: winner index and found flag. Implementation: rotate, find-first, un-rotate.
- The FSM, counters and output registers live in `dma_bus_arbiter`.

## Test plan
- **Reset mid-grant:** NUM_CH = 2, ch0 granted with 5 beats done; assert reset_n = 0 asynchronously. Expect all outputs 0 immediately and rr_ptr = 0. After release, req0 still high gives grant = 01, 1 cycle later.
- **Round-robin fairness:** NUM_CH = 4, mode = 0, req = 1111 held, each owner drops req for 1 cycle after 3 beats. Grant order is 0,1,2,3,0, with exactly 2 dead cycles between grants.
- **Fixed priority:** mode = 1, req = 0110, then req[1] drops. Grant goes to 1, then 2. With req = 1111 and each owner releasing, channel 0 is always re-granted after its release.
- **Quota:** MAX_BEATS = 4, req = 0011, bus_ack high every cycle. ch0 is forced off after 4 acks and ch1 is granted 3 cycles later. With only ch0 requesting, the grant persists past 4 beats with no gap.
- **Enable mask:** ch_enable = 10 with req = 11 gives grant = 10. Clearing ch_enable[1] mid-grant gives grant low next cycle, and grant stays low while ch_enable = 00.
- **Wrap-around:** NUM_CH = 3, rr_ptr = 2, req = 001. Winner is channel 0, grant_id = 0, and rr_ptr = 1 after release.

Source files
------------

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types for the DMA bus arbiter: arbitration mode, FSM states and the
// system default burst quota.
package dma_bus_arbiter_pkg;

  typedef enum bit {ARB_ROUND_ROBIN, ARB_FIXED_PRIO} e_arb_mode;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE} e_arb_state;

  localparam int DMA_MAX_BEATS = 256;

endpackage

// File: rtl/dma_bus_arbiter_rr_pick.sv
// Combinational winner selection: rotate the eligible mask to start at rr_ptr
// (or 0 in fixed-priority mode), find the first set bit, then un-rotate.
module arb_rr_pick
  import dma_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 1
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [ID_W-1:0]   rr_ptr,
  input  logic              mode,
  output logic [ID_W-1:0]   winner,
  output logic              found
);

  logic [NUM_CH-1:0] rotated;
  int                start;
  int                idx;
  int                offset;
  int                slot;

  always_comb begin
    start   = 0;
    idx     = 0;
    offset  = 0;
    slot    = 0;
    rotated = '0;
    found   = 1'b0;
    if (mode != 1'(ARB_FIXED_PRIO) && int'(rr_ptr) < NUM_CH) begin
      start = int'(rr_ptr);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      idx = start + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      rotated[i] = eligible[idx];
    end
    // Scan downwards so the lowest rotated position is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = i;
      end
    end
    slot = start + offset;
    if (slot >= NUM_CH) slot = slot - NUM_CH;
    winner = ID_W'(slot);
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// N-channel shared-bus arbiter with round-robin / fixed-priority selection,
// per-channel enable masking and an optional per-grant beat quota.
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int MAX_BEATS = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] req,
  input  logic              bus_ack,
  output logic [NUM_CH-1:0] grant,
  output logic              grant_valid,
  output logic [ID_W-1:0]   grant_id,
  output logic              busy
);

  localparam int BEAT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [BEAT_W-1:0] QUOTA_LAST = BEAT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);
  localparam logic [ID_W-1:0]   LAST_CH    = ID_W'(NUM_CH - 1);

  e_arb_state          state, state_d;
  logic [NUM_CH-1:0]   grant_d;
  logic [ID_W-1:0]     grant_id_d;
  logic [ID_W-1:0]     owner, owner_d;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
  logic [BEAT_W-1:0]   beat_cnt, beat_d;
  logic [NUM_CH-1:0]   eligible;
  logic [ID_W-1:0]     pick_winner;
  logic                pick_found;
  logic                quota_hit;
  logic                others_eligible;
  logic                rel_cond;

  assign eligible = req & ch_enable;

  arb_rr_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .mode     (mode),
    .winner   (pick_winner),
    .found    (pick_found)
  );

  // In GRANT the grant register is the owner's one-hot, so it masks the owner out.
  assign others_eligible = |(eligible & ~grant);
  assign quota_hit       = (MAX_BEATS != 0) && bus_ack && (beat_cnt == QUOTA_LAST);
  assign rel_cond        = !req[owner] || !ch_enable[owner] || (quota_hit && others_eligible);

  always_comb begin
    state_d    = state;
    grant_d    = grant;
    grant_id_d = grant_id;
    owner_d    = owner;
    rr_ptr_d   = rr_ptr;
    beat_d     = beat_cnt;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d    = NUM_CH'(1) << pick_winner;
          grant_id_d = pick_winner;
          owner_d    = pick_winner;
          beat_d     = '0;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // Reaching the quota always restarts the count, whether or not we release.
        if (MAX_BEATS != 0 && bus_ack) begin
          beat_d = quota_hit ? '0 : beat_cnt + BEAT_W'(1);
        end
        if (rel_cond) begin
          grant_d    = '0;
          grant_id_d = '0;
          state_d    = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        rr_ptr_d = (owner == LAST_CH) ? '0 : owner + ID_W'(1);
        state_d  = ARB_IDLE;
      end
      default: begin
        grant_d    = '0;
        grant_id_d = '0;
        state_d    = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      grant_id <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      grant_id <= grant_id_d;
      owner    <= owner_d;
      rr_ptr   <= rr_ptr_d;
      beat_cnt <= beat_d;
    end
  end

  assign grant_valid = |grant;
  assign busy        = (state != ARB_IDLE);

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: a 4-channel quota-4 instance driven from
// a vector table, plus a 3-channel instance for the wrap-around corner.
module tb_dma_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mode;
  logic [3:0] ch_enable;
  logic [3:0] req;
  logic       bus_ack;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       busy;

  logic       mode3;
  logic [2:0] ch_enable3;
  logic [2:0] req3;
  logic       bus_ack3;
  logic [2:0] grant3;
  logic       grant_valid3;
  logic [1:0] grant_id3;
  logic       busy3;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       mode;
    logic [3:0] en;
    logic [3:0] req;
    logic       ack;
    logic [3:0] exp_grant;
    logic [1:0] exp_id;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  dma_bus_arbiter #(.NUM_CH(4), .MAX_BEATS(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .ch_enable   (ch_enable),
    .req         (req),
    .bus_ack     (bus_ack),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  dma_bus_arbiter #(.NUM_CH(3), .MAX_BEATS(0)) dut3 (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode3),
    .ch_enable   (ch_enable3),
    .req         (req3),
    .bus_ack     (bus_ack3),
    .grant       (grant3),
    .grant_valid (grant_valid3),
    .grant_id    (grant_id3),
    .busy        (busy3)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic add(input logic m, input logic [3:0] en, input logic [3:0] r, input logic a,
                     input logic [3:0] g, input logic [1:0] id, input logic b);
    vec_t v;
    v.mode = m; v.en = en; v.req = r; v.ack = a;
    v.exp_grant = g; v.exp_id = id; v.exp_busy = b;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    mode      = v.mode;
    ch_enable = v.en;
    req       = v.req;
    bus_ack   = v.ack;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant3(output int cycles);
    cycles = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (grant_valid3) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0;
    mode = 1'b0; ch_enable = 4'b0; req = 4'b0; bus_ack = 1'b0;
    mode3 = 1'b0; ch_enable3 = 3'b0; req3 = 3'b0; bus_ack3 = 1'b0;

    // mode, enable, req, ack -> grant, id, busy (after the next rising edge)
    add(1, 4'b1111, 4'b0110, 0, 4'b0010, 2'd1, 1);  // fixed prio picks 1
    add(1, 4'b1111, 4'b0110, 0, 4'b0010, 2'd1, 1);
    add(1, 4'b1111, 4'b0100, 0, 4'b0000, 2'd0, 1);  // req1 drops -> RELEASE
    add(1, 4'b1111, 4'b0100, 0, 4'b0000, 2'd0, 0);
    add(1, 4'b1111, 4'b0100, 0, 4'b0100, 2'd2, 1);
    add(1, 4'b1111, 4'b0000, 0, 4'b0000, 2'd0, 1);
    add(1, 4'b1111, 4'b0000, 0, 4'b0000, 2'd0, 0);  // rr_ptr now 3
    add(0, 4'b1111, 4'b1111, 0, 4'b1000, 2'd3, 1);  // round-robin from 3
    add(0, 4'b1111, 4'b0111, 0, 4'b0000, 2'd0, 1);
    add(0, 4'b1111, 4'b1111, 0, 4'b0000, 2'd0, 0);  // rr_ptr wraps to 0
    add(0, 4'b1111, 4'b1111, 0, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b1110, 0, 4'b0000, 2'd0, 1);
    add(0, 4'b1111, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b1111, 0, 4'b0010, 2'd1, 1);
    add(0, 4'b1101, 4'b1111, 0, 4'b0000, 2'd0, 1);  // owner disabled
    add(0, 4'b1101, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b1101, 4'b1111, 0, 4'b0100, 2'd2, 1);  // masked ch1 skipped
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 2'd0, 1);
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 4'b1111, 1, 4'b0000, 2'd0, 0);  // all masked, ack ignored
    add(0, 4'b0000, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(1, 4'b1111, 4'b1111, 0, 4'b0001, 2'd0, 1);
    add(1, 4'b1111, 4'b1110, 0, 4'b0000, 2'd0, 1);
    add(1, 4'b1111, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(1, 4'b1111, 4'b1111, 0, 4'b0001, 2'd0, 1);  // ch0 re-granted in fixed prio
    add(0, 4'b1111, 4'b0011, 1, 4'b0001, 2'd0, 1);  // quota: ack 1
    add(0, 4'b1111, 4'b0011, 1, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b0011, 1, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b0011, 1, 4'b0000, 2'd0, 1);  // ack 4 with ch1 waiting
    add(0, 4'b1111, 4'b0011, 1, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0011, 1, 4'b0010, 2'd1, 1);
    add(0, 4'b1111, 4'b0010, 1, 4'b0010, 2'd1, 1);  // sole requester: no forced release
    add(0, 4'b1111, 4'b0010, 1, 4'b0010, 2'd1, 1);
    add(0, 4'b1111, 4'b0010, 1, 4'b0010, 2'd1, 1);
    add(0, 4'b1111, 4'b0010, 1, 4'b0010, 2'd1, 1);
    add(0, 4'b1111, 4'b0010, 1, 4'b0010, 2'd1, 1);
    add(0, 4'b1111, 4'b0000, 0, 4'b0000, 2'd0, 1);
    add(0, 4'b1111, 4'b0000, 0, 4'b0000, 2'd0, 0);  // rr_ptr now 2

    #12;
    check_output("reset_grant", 32'(grant), 32'h0);
    check_output("reset_valid", 32'(grant_valid), 32'h0);
    check_output("reset_id", 32'(grant_id), 32'h0);
    check_output("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("row%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check_output($sformatf("row%0d_valid", i), 32'(grant_valid), 32'(|vecs[i].exp_grant));
      check_output($sformatf("row%0d_id", i), 32'(grant_id), 32'(vecs[i].exp_id));
      check_output($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
    end
    check_output("rr_ptr_after_table", 32'(dut.rr_ptr), 32'd2);

    // Asynchronous reset in the middle of a grant with beats in flight.
    mode = 1'b0; ch_enable = 4'b1111; req = 4'b0001; bus_ack = 1'b0;
    @(posedge clk); #1;
    check_output("midrst_grant", 32'(grant), 32'h1);
    bus_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_output($sformatf("midrst_beat%0d_grant", i + 1), 32'(grant), 32'h1);
    end
    #3;
    reset_n = 1'b0;
    #1;
    check_output("async_rst_grant", 32'(grant), 32'h0);
    check_output("async_rst_valid", 32'(grant_valid), 32'h0);
    check_output("async_rst_busy", 32'(busy), 32'h0);
    check_output("async_rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    check_output("async_rst_beat_cnt", 32'(dut.beat_cnt), 32'h0);
    bus_ack = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_output("post_rst_grant", 32'(grant), 32'h1);
    check_output("post_rst_id", 32'(grant_id), 32'h0);
    req = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Wrap-around on the 3-channel instance: rr_ptr = 2, only ch0 requests.
    ch_enable3 = 3'b111;
    req3 = 3'b010;
    wait_grant3(cyc);
    check_output("wrap_first_latency", 32'(cyc), 32'd1);
    check_output("wrap_first_grant", 32'(grant3), 32'b010);
    check_output("wrap_first_id", 32'(grant_id3), 32'd1);
    req3 = 3'b000;
    @(posedge clk); #1;
    check_output("wrap_release_grant", 32'(grant3), 32'h0);
    check_output("wrap_release_busy", 32'(busy3), 32'h1);
    @(posedge clk); #1;
    check_output("wrap_idle_busy", 32'(busy3), 32'h0);
    check_output("wrap_rr_ptr_2", 32'(dut3.rr_ptr), 32'd2);
    req3 = 3'b001;
    wait_grant3(cyc);
    check_output("wrap_second_latency", 32'(cyc), 32'd1);
    check_output("wrap_second_grant", 32'(grant3), 32'b001);
    check_output("wrap_second_id", 32'(grant_id3), 32'd0);
    req3 = 3'b000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("wrap_rr_ptr_1", 32'(dut3.rr_ptr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
